mouse_packet_assembler: RTL and testbench

- Downstream of the PS/2 byte receiver; consumes its BYTE_READY/BYTE_READ/BYTE_ERROR_CODE stream.
- Frames the standard 3-byte mouse packet (status, X, Y), checks framing, and emits 9-bit signed deltas plus button state to the master/pointer logic.
- Holds the result under a valid/ack handshake.
- Drives the receiver's READ_ENABLE.

---
 rtl/mouse_pkg.sv | 32 +++
 rtl/mouse_timeout_counter.sv | 29 ++
 rtl/mouse_packet_assembler.sv | 144 ++++++++++++++
 tb/tb_mouse_packet_assembler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet path: FSM encoding, status-byte
// bit positions and the default inter-byte timeout.
package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    // 2 ms at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    // Overflowed axes clamp to the extreme of their sign.
    function automatic logic [8:0] sat_delta(input logic sign, input logic ovf,
                                             input logic [7:0] raw);
        if (ovf)
            return sign ? 9'h100 : 9'h0FF;
        return {sign, raw};
    endfunction

endpackage

// File: rtl/mouse_timeout_counter.sv
// Free-running cycle counter with synchronous clear; expire is high during the
// LIMIT-th consecutive enabled cycle.
module mouse_timeout_counter #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/mouse_packet_assembler.sv
// Frames 3-byte PS/2 mouse packets into buttons and 9-bit signed deltas held
// under a valid/ack handshake. Define MOUSE_OVF_SAT_EN to clamp overflowed axes.
module mouse_packet_assembler
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic [7:0]           BYTE_READ,
    input  logic [1:0]           BYTE_ERROR_CODE,
    input  logic                 BYTE_READY,
    output logic                 READ_ENABLE,
    output logic                 PACKET_VALID,
    input  logic                 PACKET_ACK,
    output logic [2:0]           BUTTONS,
    output logic [8:0]           DX,
    output logic [8:0]           DY,
    output logic [1:0]           OVF,
    output logic                 OVERRUN,
    output logic [ERR_CNT_W-1:0] ERR_COUNT
);

    state_t     state, state_n;
    logic [7:0] status_q, x_q, y_q;
    logic       latch_s, latch_x, latch_y, drop, publish;
    logic       counting, expire;
    logic       byte_ok;

    assign byte_ok  = (BYTE_ERROR_CODE == 2'b00);
    assign counting = ENABLE && (state == WAIT_B1 || state == WAIT_B2);

    mouse_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .clear  (!counting || latch_x || latch_y || drop),
        .enable (counting),
        .expire (expire)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= WAIT_B0;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        latch_s = 1'b0;
        latch_x = 1'b0;
        latch_y = 1'b0;
        drop    = 1'b0;
        publish = 1'b0;
        if (!ENABLE) begin
            state_n = WAIT_B0;
        end else begin
            case (state)
                WAIT_B0: begin
                    if (BYTE_READY) begin
                        if (!byte_ok || !BYTE_READ[SYNC]) begin
                            drop = 1'b1;
                        end else begin
                            latch_s = 1'b1;
                            state_n = WAIT_B1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (BYTE_READY && byte_ok) begin
                        latch_x = 1'b1;
                        state_n = WAIT_B2;
                    end else if (BYTE_READY || expire) begin
                        drop    = 1'b1;
                        state_n = WAIT_B0;
                    end
                end
                WAIT_B2: begin
                    if (BYTE_READY && byte_ok) begin
                        latch_y = 1'b1;
                        state_n = PUBLISH;
                    end else if (BYTE_READY || expire) begin
                        drop    = 1'b1;
                        state_n = WAIT_B0;
                    end
                end
                PUBLISH: begin
                    publish = 1'b1;
                    state_n = WAIT_B0;
                end
                default: state_n = WAIT_B0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            status_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            if (latch_s) status_q <= BYTE_READ;
            if (latch_x) x_q      <= BYTE_READ;
            if (latch_y) y_q      <= BYTE_READ;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            READ_ENABLE  <= 1'b0;
            PACKET_VALID <= 1'b0;
            BUTTONS      <= '0;
            DX           <= '0;
            DY           <= '0;
            OVF          <= '0;
            OVERRUN      <= 1'b0;
            ERR_COUNT    <= '0;
        end else begin
            READ_ENABLE <= ENABLE;
            OVERRUN     <= 1'b0;
            if (publish) begin
                // Ack in the publish cycle retires the old packet, so no overrun.
                OVERRUN      <= PACKET_VALID && !PACKET_ACK;
                PACKET_VALID <= 1'b1;
                BUTTONS      <= {status_q[BTN_M], status_q[BTN_R], status_q[BTN_L]};
                OVF          <= {status_q[YO], status_q[XO]};
`ifdef MOUSE_OVF_SAT_EN
                DX           <= sat_delta(status_q[XS], status_q[XO], x_q);
                DY           <= sat_delta(status_q[YS], status_q[YO], y_q);
`else
                DX           <= {status_q[XS], x_q};
                DY           <= {status_q[YS], y_q};
`endif
            end else if (PACKET_VALID && PACKET_ACK) begin
                PACKET_VALID <= 1'b0;
            end
            if (drop && (ERR_COUNT != {ERR_CNT_W{1'b1}}))
                ERR_COUNT <= ERR_COUNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_mouse_packet_assembler.sv
// Directed-vector bench for mouse_packet_assembler with a short timeout.
module tb_mouse_packet_assembler;

    localparam int TMO = 16;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ENABLE = 1'b0;
    logic [7:0] BYTE_READ = '0;
    logic [1:0] BYTE_ERROR_CODE = '0;
    logic       BYTE_READY = 1'b0;
    logic       READ_ENABLE;
    logic       PACKET_VALID;
    logic       PACKET_ACK = 1'b0;
    logic [2:0] BUTTONS;
    logic [8:0] DX, DY;
    logic [1:0] OVF;
    logic       OVERRUN;
    logic [7:0] ERR_COUNT;

    int errors = 0;
    int checks = 0;

    mouse_packet_assembler #(.TIMEOUT_CYCLES(TMO), .ERR_CNT_W(8)) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .ENABLE          (ENABLE),
        .BYTE_READ       (BYTE_READ),
        .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
        .BYTE_READY      (BYTE_READY),
        .READ_ENABLE     (READ_ENABLE),
        .PACKET_VALID    (PACKET_VALID),
        .PACKET_ACK      (PACKET_ACK),
        .BUTTONS         (BUTTONS),
        .DX              (DX),
        .DY              (DY),
        .OVF             (OVF),
        .OVERRUN         (OVERRUN),
        .ERR_COUNT       (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] code);
        BYTE_READ       = b;
        BYTE_ERROR_CODE = code;
        BYTE_READY      = 1'b1;
        tick(1);
        BYTE_READY      = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 2'b00);
        send_byte(b1, 2'b00);
        send_byte(b2, 2'b00);
    endtask

    task automatic ack();
        PACKET_ACK = 1'b1;
        tick(1);
        PACKET_ACK = 1'b0;
    endtask

    task automatic chk_pkt(input string tag, input logic [2:0] btn, input logic [8:0] dx,
                           input logic [8:0] dy, input logic [1:0] ovf);
        chk({tag, ".valid"}, PACKET_VALID, 1'b1);
        chk({tag, ".btn"},   BUTTONS, btn);
        chk({tag, ".dx"},    DX, dx);
        chk({tag, ".dy"},    DY, dy);
        chk({tag, ".ovf"},   OVF, ovf);
    endtask

    initial begin
        #2;
        chk("rst.valid", PACKET_VALID, 1'b0);
        chk("rst.dx",    DX, 9'h000);
        chk("rst.err",   ERR_COUNT, 8'd0);
        chk("rst.rden",  READ_ENABLE, 1'b0);
        tick(1);
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        tick(2);
        chk("rden.on", READ_ENABLE, 1'b1);

        // Basic packet and its two-cycle latency
        send_pkt(8'h09, 8'h05, 8'hFB);
        chk("p1.lat", PACKET_VALID, 1'b0);
        tick(1);
        chk_pkt("p1", 3'b001, 9'h005, 9'h0FB, 2'b00);
        chk("p1.ovr", OVERRUN, 1'b0);
        ack();
        chk("p1.ack", PACKET_VALID, 1'b0);
        ack();
        chk("ack.idle", PACKET_VALID, 1'b0);

        // Negative deltas
        send_pkt(8'h38, 8'hFE, 8'h02);
        tick(1);
        chk_pkt("p2", 3'b000, 9'h1FE, 9'h102, 2'b00);
        ack();

        // Missing sync bit on the status byte
        send_byte(8'h01, 2'b00);
        chk("sync.err", ERR_COUNT, 8'd1);
        send_pkt(8'h0A, 8'h10, 8'h20);
        tick(1);
        chk_pkt("p3", 3'b010, 9'h010, 9'h020, 2'b00);
        ack();

        // Parity error on the X byte
        send_byte(8'h08, 2'b00);
        send_byte(8'h33, 2'b01);
        chk("par.err", ERR_COUNT, 8'd2);
        tick(3);
        chk("par.novalid", PACKET_VALID, 1'b0);
        send_pkt(8'h0C, 8'h01, 8'h02);
        tick(1);
        chk_pkt("p4", 3'b100, 9'h001, 9'h002, 2'b00);
        ack();

        // Timeout after the status byte: expires on the TMO-th idle cycle
        send_byte(8'h08, 2'b00);
        tick(TMO - 1);
        chk("tmo.early", ERR_COUNT, 8'd2);
        tick(1);
        chk("tmo.err", ERR_COUNT, 8'd3);
        send_pkt(8'h09, 8'h03, 8'h04);
        tick(1);
        chk_pkt("p5", 3'b001, 9'h003, 9'h004, 2'b00);

        // Second packet without ack overruns the first
        send_pkt(8'h0A, 8'h07, 8'h08);
        tick(1);
        chk("ovr.pulse", OVERRUN, 1'b1);
        chk_pkt("p6", 3'b010, 9'h007, 9'h008, 2'b00);
        tick(1);
        chk("ovr.end", OVERRUN, 1'b0);

        // Ack coinciding with publish keeps valid high with new data, no overrun
        send_pkt(8'h08, 8'h11, 8'h22);
        ack();
        chk("ackpub.ovr", OVERRUN, 1'b0);
        chk_pkt("p7", 3'b000, 9'h011, 9'h022, 2'b00);
        ack();
        chk("p7.ack", PACKET_VALID, 1'b0);

        // ENABLE low aborts the partial packet and ignores bytes
        send_byte(8'h08, 2'b00);
        ENABLE = 1'b0;
        tick(1);
        chk("dis.rden", READ_ENABLE, 1'b0);
        send_byte(8'h55, 2'b00);
        chk("dis.err", ERR_COUNT, 8'd3);
        ENABLE = 1'b1;
        tick(1);
        send_pkt(8'h09, 8'h21, 8'h22);
        tick(1);
        chk_pkt("p8", 3'b001, 9'h021, 9'h022, 2'b00);
        chk("p8.err", ERR_COUNT, 8'd3);
        ack();

        // X overflow with negative sign
        send_pkt(8'h58, 8'h20, 8'h30);
        tick(1);
`ifdef MOUSE_OVF_SAT_EN
        chk_pkt("ovf", 3'b000, 9'h100, 9'h030, 2'b01);
`else
        chk_pkt("ovf", 3'b000, 9'h120, 9'h030, 2'b01);
`endif

        // Asynchronous reset mid-packet
        send_byte(8'h08, 2'b00);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst.valid", PACKET_VALID, 1'b0);
        chk("arst.dx",    DX, 9'h000);
        chk("arst.ovf",   OVF, 2'b00);
        chk("arst.err",   ERR_COUNT, 8'd0);
        tick(1);
        RESET_N = 1'b1;
        tick(1);
        send_pkt(8'h0B, 8'h44, 8'h55);
        tick(1);
        chk_pkt("p9", 3'b011, 9'h044, 9'h055, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
